// File: rtl/cluster_load_ctrl_pkg.sv
// Shared eyeriss package: controller state encoding, idle multicast tag and
// the width of the per-PE word counts.
package cluster_load_ctrl_pkg;

  localparam int COUNT_W = 8;

  // All-ones tag; modules slice the low idSize bits.
  localparam logic [63:0] IDLE_TAG = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_LOAD_A,
    S_DRAIN,
    S_START,
    S_WAIT
  } state_t;

endpackage

// File: rtl/cluster_load_ctrl_if.sv
// Bus between the cluster load controller and its memories / PE cluster.
// The controller uses the master modport, the environment the slave modport.
interface cluster_load_ctrl_if #(
  parameter int dataSize = 8,
  parameter int addrSize = 16,
  parameter int idSize   = 8
);
  import cluster_load_ctrl_pkg::*;

  logic                start_i;
  logic [COUNT_W-1:0]  ctrl_wcount;
  logic [COUNT_W-1:0]  ctrl_acount;

  logic                w_rd_en_o;
  logic                a_rd_en_o;
  logic [addrSize-1:0] w_rd_addr_o;
  logic [addrSize-1:0] a_rd_addr_o;
  logic [dataSize-1:0] w_rd_data_i;
  logic [dataSize-1:0] a_rd_data_i;

  logic [dataSize-1:0] w_data_o;
  logic [dataSize-1:0] a_data_o;
  logic [idSize-1:0]   weight_tag_x_o;
  logic [idSize-1:0]   weight_tag_y_o;
  logic [idSize-1:0]   act_tag_x_o;
  logic [idSize-1:0]   act_tag_y_o;
  logic                cluster_enable_o;
  logic                start_compute_o;
  logic                cluster_done_i;

  logic                busy_o;
  logic                done_o;

  modport master (
    input  start_i, ctrl_wcount, ctrl_acount,
    input  w_rd_data_i, a_rd_data_i, cluster_done_i,
    output w_rd_en_o, a_rd_en_o, w_rd_addr_o, a_rd_addr_o,
    output w_data_o, a_data_o,
    output weight_tag_x_o, weight_tag_y_o, act_tag_x_o, act_tag_y_o,
    output cluster_enable_o, start_compute_o, busy_o, done_o
  );

  modport slave (
    output start_i, ctrl_wcount, ctrl_acount,
    output w_rd_data_i, a_rd_data_i, cluster_done_i,
    input  w_rd_en_o, a_rd_en_o, w_rd_addr_o, a_rd_addr_o,
    input  w_data_o, a_data_o,
    input  weight_tag_x_o, weight_tag_y_o, act_tag_x_o, act_tag_y_o,
    input  cluster_enable_o, start_compute_o, busy_o, done_o
  );

endinterface

// File: rtl/cluster_load_ctrl_tag_sequencer.sv
// Nested word / tx / ty counters walking every PE target of one load phase.
// 'last' flags the final read of the phase; all counters then wrap to zero,
// so the same instance is ready for the next phase without extra clearing.
module tag_sequencer
  import cluster_load_ctrl_pkg::*;
#(
  parameter int numPeX = 3,
  parameter int numPeY = 3,
  parameter int idSize = 8
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               clear,
  input  logic               advance,
  input  logic [COUNT_W-1:0] count,
  output logic [idSize-1:0]  tx,
  output logic [idSize-1:0]  ty,
  output logic               last
);

  localparam logic [idSize-1:0] LAST_X = idSize'(numPeX - 1);
  localparam logic [idSize-1:0] LAST_Y = idSize'(numPeY - 1);

  logic [COUNT_W-1:0] word;
  logic               word_end;
  logic               row_end;

  // Wrap conditions for each counter level and the end-of-phase flag.
  always_comb begin
    word_end = (word == count - COUNT_W'(1));
    row_end  = (tx == LAST_X);
    last     = word_end && row_end && (ty == LAST_Y);
  end

  // Word counter innermost, then tx, then ty.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      word <= '0;
      tx   <= '0;
      ty   <= '0;
    end else if (clear) begin
      word <= '0;
      tx   <= '0;
      ty   <= '0;
    end else if (advance) begin
      if (word_end) begin
        word <= '0;
        if (row_end) begin
          tx <= '0;
          if (ty == LAST_Y) begin
            ty <= '0;
          end else begin
            ty <= ty + idSize'(1);
          end
        end else begin
          tx <= tx + idSize'(1);
        end
      end else begin
        word <= word + COUNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/cluster_load_ctrl.sv
// Cluster load controller: streams weights then activations from memory to
// every PE with multicast tags, then kicks off compute and waits for the
// cluster to finish.
module cluster_load_ctrl
  import cluster_load_ctrl_pkg::*;
#(
  parameter int numPeX   = 3,
  parameter int numPeY   = 3,
  parameter int dataSize = 8,
  parameter int addrSize = 16,
  parameter int idSize   = 8
) (
  input logic                 clk,
  input logic                 nrst,
  cluster_load_ctrl_if.master bus
);

  localparam logic [idSize-1:0] IDLE_ID = IDLE_TAG[idSize-1:0];

  state_t              state;
  state_t              next_state;
  logic [COUNT_W-1:0]  wcount_q;
  logic [COUNT_W-1:0]  acount_q;
  logic [COUNT_W-1:0]  seq_count;
  logic [addrSize-1:0] addr_q;
  logic [idSize-1:0]   tx;
  logic [idSize-1:0]   ty;
  logic                seq_last;
  logic                w_strobe;
  logic                a_strobe;
  logic                start_compute;
  logic                busy;
  logic                done;
  logic                w_valid_q;
  logic                a_valid_q;
  logic [idSize-1:0]   w_tag_x_q;
  logic [idSize-1:0]   w_tag_y_q;
  logic [idSize-1:0]   a_tag_x_q;
  logic [idSize-1:0]   a_tag_y_q;

  // The phase in progress chooses which latched count drives the sequencer.
  always_comb begin
    seq_count = (state == S_LOAD_A) ? acount_q : wcount_q;
  end

  tag_sequencer #(
    .numPeX (numPeX),
    .numPeY (numPeY),
    .idSize (idSize)
  ) u_tag_sequencer (
    .clk     (clk),
    .nrst    (nrst),
    .clear   (state == S_IDLE),
    .advance (w_strobe || a_strobe),
    .count   (seq_count),
    .tx      (tx),
    .ty      (ty),
    .last    (seq_last)
  );

  // State register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; zero counts skip their load phase entirely.
  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE: begin
        if (bus.start_i) begin
          if (bus.ctrl_wcount != '0) begin
            next_state = S_LOAD_W;
          end else if (bus.ctrl_acount != '0) begin
            next_state = S_LOAD_A;
          end else begin
            next_state = S_DRAIN;
          end
        end
      end
      S_LOAD_W: begin
        if (seq_last) begin
          next_state = (acount_q == '0) ? S_DRAIN : S_LOAD_A;
        end
      end
      S_LOAD_A: begin
        if (seq_last) begin
          next_state = S_DRAIN;
        end
      end
      S_DRAIN: next_state = S_START;
      S_START: next_state = S_WAIT;
      S_WAIT: begin
        if (bus.cluster_done_i) begin
          next_state = S_IDLE;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Per-state strobes and status outputs.
  always_comb begin
    w_strobe      = (state == S_LOAD_W);
    a_strobe      = (state == S_LOAD_A);
    start_compute = (state == S_START);
    busy          = (state != S_IDLE);
    done          = (state == S_WAIT) && bus.cluster_done_i;
  end

  // Counts are captured only on an accepted start so later changes are ignored.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wcount_q <= '0;
      acount_q <= '0;
    end else if ((state == S_IDLE) && bus.start_i) begin
      wcount_q <= bus.ctrl_wcount;
      acount_q <= bus.ctrl_acount;
    end
  end

  // Read address counts up through a phase and restarts at 0 for the next.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      addr_q <= '0;
    end else if (w_strobe || a_strobe) begin
      addr_q <= seq_last ? '0 : addr_q + addrSize'(1);
    end else begin
      addr_q <= '0;
    end
  end

  // Tags and valid flags lag the strobe by one cycle to meet the read data.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      w_valid_q <= 1'b0;
      a_valid_q <= 1'b0;
      w_tag_x_q <= IDLE_ID;
      w_tag_y_q <= IDLE_ID;
      a_tag_x_q <= IDLE_ID;
      a_tag_y_q <= IDLE_ID;
    end else begin
      w_valid_q <= w_strobe;
      a_valid_q <= a_strobe;
      w_tag_x_q <= w_strobe ? tx : IDLE_ID;
      w_tag_y_q <= w_strobe ? ty : IDLE_ID;
      a_tag_x_q <= a_strobe ? tx : IDLE_ID;
      a_tag_y_q <= a_strobe ? ty : IDLE_ID;
    end
  end

  assign bus.w_rd_en_o        = w_strobe;
  assign bus.a_rd_en_o        = a_strobe;
  assign bus.w_rd_addr_o      = w_strobe ? addr_q : '0;
  assign bus.a_rd_addr_o      = a_strobe ? addr_q : '0;
  assign bus.w_data_o         = w_valid_q ? bus.w_rd_data_i : {dataSize{1'b0}};
  assign bus.a_data_o         = a_valid_q ? bus.a_rd_data_i : {dataSize{1'b0}};
  assign bus.weight_tag_x_o   = w_tag_x_q;
  assign bus.weight_tag_y_o   = w_tag_y_q;
  assign bus.act_tag_x_o      = a_tag_x_q;
  assign bus.act_tag_y_o      = a_tag_y_q;
  assign bus.cluster_enable_o = w_valid_q || a_valid_q;
  assign bus.start_compute_o  = start_compute;
  assign bus.busy_o           = busy;
  assign bus.done_o           = done;

endmodule

// File: tb/tb_cluster_load_ctrl.sv
// Self-checking bench for cluster_load_ctrl on a 3x3 PE array. Expected
// per-cycle behaviour is built from a timeline of reads derived from the
// counts, with a memory model whose contents are a function of address.
module tb_cluster_load_ctrl;

  localparam int NX = 3;
  localparam int NY = 3;

  logic clk;
  logic nrst;
  int   checks;
  int   errors;
  logic [7:0] wSeed;
  logic [7:0] aSeed;

  cluster_load_ctrl_if #(.dataSize(8), .addrSize(16), .idSize(8)) bus ();

  cluster_load_ctrl #(
    .numPeX   (NX),
    .numPeY   (NY),
    .dataSize (8),
    .addrSize (16),
    .idSize   (8)
  ) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] memW(input logic [15:0] addr);
    return 8'(addr[7:0] * 8'd13) ^ wSeed;
  endfunction

  function automatic logic [7:0] memA(input logic [15:0] addr);
    return 8'(addr[7:0] * 8'd29) + aSeed;
  endfunction

  // Memories answer one cycle after a strobe; garbage otherwise.
  always @(posedge clk) begin
    bus.w_rd_data_i <= bus.w_rd_en_o ? memW(bus.w_rd_addr_o) : 8'($urandom);
    bus.a_rd_data_i <= bus.a_rd_en_o ? memA(bus.a_rd_addr_o) : 8'($urandom);
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkIdleOutputs(input string ctx);
    checkOutput({ctx, "_w_rd_en"}, 64'(bus.w_rd_en_o), 64'(0));
    checkOutput({ctx, "_a_rd_en"}, 64'(bus.a_rd_en_o), 64'(0));
    checkOutput({ctx, "_enable"}, 64'(bus.cluster_enable_o), 64'(0));
    checkOutput({ctx, "_start"}, 64'(bus.start_compute_o), 64'(0));
    checkOutput({ctx, "_busy"}, 64'(bus.busy_o), 64'(0));
    checkOutput({ctx, "_done"}, 64'(bus.done_o), 64'(0));
    checkOutput({ctx, "_wtags"}, 64'({bus.weight_tag_x_o, bus.weight_tag_y_o}), 64'(16'hFFFF));
    checkOutput({ctx, "_atags"}, 64'({bus.act_tag_x_o, bus.act_tag_y_o}), 64'(16'hFFFF));
    checkOutput({ctx, "_w_data"}, 64'(bus.w_data_o), 64'(0));
    checkOutput({ctx, "_a_data"}, 64'(bus.a_data_o), 64'(0));
  endtask

  // One full load-and-compute run. extraAt injects an ignored start pulse
  // on that cycle; waitLen is how long the cluster stays busy.
  task automatic applyStimulus(input int wc, input int ac, input int extraAt, input int waitLen);
    int nw, na, startC, doneC, idx, cnt;
    logic expW, expA, prevW, prevA;
    logic [7:0] etx, ety;
    nw     = NX * NY * wc;
    na     = NX * NY * ac;
    startC = nw + na + 1;
    doneC  = startC + 1 + waitLen;
    wSeed  = 8'($urandom);
    aSeed  = 8'($urandom);
    bus.ctrl_wcount = 8'(wc);
    bus.ctrl_acount = 8'(ac);
    bus.start_i     = 1'b1;
    @(posedge clk);
    #1;
    bus.start_i     = 1'b0;
    bus.ctrl_wcount = 8'($urandom);
    bus.ctrl_acount = 8'($urandom);
    for (int c = 0; c <= doneC + 1; c++) begin
      bus.cluster_done_i = (c == doneC);
      bus.start_i        = (c == extraAt);
      #1;
      if (c <= doneC) begin
        expW  = (c < nw);
        expA  = (c >= nw) && (c < nw + na);
        prevW = (c >= 1) && (c - 1 < nw);
        prevA = (c - 1 >= nw) && (c - 1 < nw + na);
        checkOutput($sformatf("c%0d_w_rd_en", c), 64'(bus.w_rd_en_o), 64'(expW));
        checkOutput($sformatf("c%0d_a_rd_en", c), 64'(bus.a_rd_en_o), 64'(expA));
        if (expW) checkOutput($sformatf("c%0d_w_addr", c), 64'(bus.w_rd_addr_o), 64'(c));
        if (expA) checkOutput($sformatf("c%0d_a_addr", c), 64'(bus.a_rd_addr_o), 64'(c - nw));
        checkOutput($sformatf("c%0d_enable", c), 64'(bus.cluster_enable_o), 64'(prevW || prevA));
        etx = 8'hFF;
        ety = 8'hFF;
        if (prevW || prevA) begin
          idx = prevW ? c - 1 : c - 1 - nw;
          cnt = prevW ? wc : ac;
          etx = 8'((idx / cnt) % NX);
          ety = 8'((idx / cnt) / NX);
        end
        checkOutput($sformatf("c%0d_wtags", c), 64'({bus.weight_tag_x_o, bus.weight_tag_y_o}),
                    prevW ? 64'({etx, ety}) : 64'(16'hFFFF));
        checkOutput($sformatf("c%0d_atags", c), 64'({bus.act_tag_x_o, bus.act_tag_y_o}),
                    prevA ? 64'({etx, ety}) : 64'(16'hFFFF));
        checkOutput($sformatf("c%0d_w_data", c), 64'(bus.w_data_o),
                    prevW ? 64'(memW(16'(c - 1))) : 64'(0));
        checkOutput($sformatf("c%0d_a_data", c), 64'(bus.a_data_o),
                    prevA ? 64'(memA(16'(c - 1 - nw))) : 64'(0));
        checkOutput($sformatf("c%0d_start", c), 64'(bus.start_compute_o), 64'(c == startC));
        checkOutput($sformatf("c%0d_busy", c), 64'(bus.busy_o), 64'(1));
        checkOutput($sformatf("c%0d_done", c), 64'(bus.done_o), 64'(c == doneC));
      end else begin
        checkIdleOutputs("after_done");
      end
      @(posedge clk);
      #1;
    end
    bus.cluster_done_i = 1'b0;
    bus.start_i        = 1'b0;
  endtask

  initial begin
    checks             = 0;
    errors             = 0;
    wSeed              = 8'h00;
    aSeed              = 8'h00;
    nrst               = 1'b0;
    bus.start_i        = 1'b0;
    bus.ctrl_wcount    = 8'd0;
    bus.ctrl_acount    = 8'd0;
    bus.cluster_done_i = 1'b0;

    #12;
    checkIdleOutputs("reset");
    @(posedge clk);
    #1;
    nrst = 1'b1;
    @(posedge clk);
    #1;
    checkIdleOutputs("post_reset");

    $display("[TB] wcount=2 acount=3 with stray start during activation load");
    applyStimulus(2, 3, 25, 2);

    $display("[TB] wcount=0 acount=1");
    applyStimulus(0, 1, -1, 0);

    $display("[TB] both counts zero");
    applyStimulus(0, 0, -1, 1);

    $display("[TB] wcount=3 acount=0");
    applyStimulus(3, 0, 10, 3);

    $display("[TB] reset asserted at weight read 5");
    bus.ctrl_wcount = 8'd2;
    bus.ctrl_acount = 8'd1;
    bus.start_i     = 1'b1;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("mid_load_addr", 64'(bus.w_rd_addr_o), 64'(5));
    nrst = 1'b0;
    #1;
    checkIdleOutputs("rst_mid");
    @(posedge clk);
    #1;
    nrst = 1'b1;
    @(posedge clk);
    #1;
    checkIdleOutputs("rst_release");
    applyStimulus(2, 1, -1, 1);

    $display("[TB] randomized runs");
    for (int r = 0; r < 4; r++) begin
      applyStimulus(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), -1,
                    int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cluster_load_ctrl.md
CLUSTER_LOAD_CTRL -- requirements
Module: cluster_load_ctrl

Interface
REQ-001 Parameters SHALL be: numPeX, default 3, PE columns; numPeY, default 3, PE rows; dataSize, default 8, data word width; addrSize, default 16, memory address width; idSize, default 8, multicast tag width.
REQ-002 clk  in  1  clock; nrst  in  1  reset, asynchronous, active-low.
REQ-003 start_i  in  1  single-cycle load-and-compute request.
REQ-004 ctrl_wcount / ctrl_acount  in  8 each  weight / activation words per PE.
REQ-005 w_rd_en_o, a_rd_en_o  out  1 each  memory read strobes.
REQ-006 w_rd_addr_o, a_rd_addr_o  out  addrSize each  memory read addresses.
REQ-007 w_rd_data_i, a_rd_data_i  in  dataSize each  read data, valid exactly 1 cycle after the strobe.
REQ-008 w_data_o, a_data_o  out  dataSize each  cluster data inputs.
REQ-009 weight_tag_x_o, weight_tag_y_o, act_tag_x_o, act_tag_y_o  out  idSize each  cluster multicast tag targets.
REQ-010 cluster_enable_o  out  1  multicast enable, high only on cycles carrying valid data.
REQ-011 start_compute_o  out  1  compute start pulse to the cluster.
REQ-012 cluster_done_i  in  1  cluster completion flag.
REQ-013 busy_o  out  1  high in any non-IDLE state.
REQ-014 done_o  out  1  single-cycle completion pulse.

Function
REQ-015 States SHALL be S_IDLE, S_LOAD_W, S_LOAD_A, S_DRAIN, S_START and S_WAIT.
REQ-016 In S_IDLE, start_i SHALL go to S_LOAD_W, or to S_LOAD_A if ctrl_wcount==0, or to S_DRAIN if both counts are 0.
REQ-017 The loader SHALL latch both counts at start_i; start_i is ignored while busy_o=1.
REQ-018 The load phase SHALL visit targets in order ty=0..numPeY-1 (outer), tx=0..numPeX-1 (inner), issuing count consecutive reads per target.
REQ-019 Each load state SHALL issue one read per cycle, with the address starting at 0 and incrementing by 1.
REQ-020 Each phase SHALL issue numPeX*numPeY*count reads in total.
REQ-021 S_LOAD_W SHALL go to S_LOAD_A after its last read, or to S_DRAIN if ctrl_acount==0.
REQ-022 S_LOAD_A SHALL go to S_DRAIN after its last read.
REQ-023 The tag, data and enable outputs SHALL be registered one cycle after the read strobe, aligned with the returning memory data; the latency from strobe to cluster_enable_o is exactly 1 cycle.
REQ-024 On weight data cycles, weight tags SHALL equal (tx,ty) and activation tags SHALL be the idle tag.
REQ-025 On activation data cycles, activation tags SHALL equal (tx,ty) and weight tags SHALL be the idle tag.
REQ-026 The idle tag SHALL be all-ones; outside data cycles all four tags SHALL be the idle tag.
REQ-027 w_data_o and a_data_o SHALL pass the read data, and be 0 when not valid.
REQ-028 S_DRAIN SHALL last 1 cycle so the final data word is delivered; it then goes to S_START.
REQ-029 S_START SHALL assert start_compute_o for exactly 1 cycle, then go to S_WAIT.
REQ-030 S_WAIT SHALL return to S_IDLE on the first cycle cluster_done_i=1 and pulse done_o in that cycle.
REQ-031 The per-PE word counter SHALL wrap to 0 after count-1; the tx counter SHALL wrap after numPeX-1, incrementing ty.
REQ-032 Addresses SHALL be modulo 2^addrSize, with no overflow flag.

Reset
REQ-033 On nrst=0 the block SHALL be in S_IDLE with all counters and addresses 0, all strobes, enables and pulses 0, data outputs 0, and all tags all-ones.
REQ-034 Reset asserted mid-load SHALL abort immediately with no further read strobes; cluster_enable_o SHALL be 0 on the first cycle after deassertion.

Structure
REQ-035 The state enum, the idle tag constant (all-ones) and the count width (8) SHALL reside in the shared eyeriss package.
REQ-036 A single sub-module, tag_sequencer (word/tx/ty nested counters with a last flag), SHALL be instantiated once and reused for both phases.

Verification
REQ-037 With wcount=2, acount=3 and 3x3 PEs, start_i SHALL produce 18 weight reads (addr 0..17) then 27 activation reads (addr 0..26).
REQ-038 In the same run, tags SHALL read (0,0),(0,0),(1,0),(1,0),...,(2,2) in weight data cycles.
REQ-039 With wcount=0 and acount=1, there SHALL be no weight strobes, 9 activation reads, then start_compute_o one cycle after the drain.
REQ-040 With both counts 0, start_i SHALL lead via S_DRAIN to start_compute_o 2 cycles after start_i.
REQ-041 A start_i pulse during S_LOAD_A SHALL be ignored, with reads and addresses unchanged.
REQ-042 Asserting nrst at weight read 5 SHALL return all outputs to reset values, and a new start_i SHALL restart reads from addr 0.
